text_view_reader: RTL and testbench

- Consumer end of the text buffer's iteration interface.
- On a refresh request it drives full_iter_start/iter_en and collects every symbol plus the cursor flags.
- It writes one display row of character cells (glyph codes) into a row memory through a simple write port, then pads the rest of the row with blanks.
- Sits between the text buffer and the character-cell display/plot overlay.

---
 rtl/text_pkg.sv | 26 ++
 rtl/text_view_reader_if.sv | 37 +++
 rtl/text_view_reader.sv | 148 ++++++++++++++
 tb/tb_text_view_reader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared types and constants for the text view reader.
// TEXT_VIEW_READER_CURSOR_MARK_EN widens cell data by one cursor-mark bit.
package text_pkg;

  localparam int unsigned SYMBOL_WIDTH = 7;

  typedef logic [SYMBOL_WIDTH-1:0] symbol_t;

  localparam symbol_t BLANK_CODE = 7'h20;
  localparam symbol_t END_SYMBOL = 7'h00;

`ifdef TEXT_VIEW_READER_CURSOR_MARK_EN
  localparam int unsigned WR_DATA_WIDTH = SYMBOL_WIDTH + 1;
`else
  localparam int unsigned WR_DATA_WIDTH = SYMBOL_WIDTH;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN,
    ST_PAD,
    ST_DONE
  } reader_state_e;

endpackage

// File: rtl/text_view_reader_if.sv
// Iteration handshake with the text buffer plus the row-memory write port.
interface text_view_reader_if
  import text_pkg::*;
#(
  parameter int unsigned COLUMNS = 80
);

  localparam int unsigned COL_WIDTH = $clog2(COLUMNS + 1);

  logic                     refresh;
  logic                     busy;
  logic                     done;
  logic                     full_iter_start;
  logic                     iter_en;
  symbol_t                  iter_out;
  logic                     iter_out_valid;
  logic                     cursor_left;
  logic                     cursor_right;
  logic                     wr_en;
  logic [COL_WIDTH-1:0]     wr_addr;
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic [COL_WIDTH-1:0]     cursor_col;
  logic                     truncated;

  modport master (
    input  refresh, iter_out, iter_out_valid, cursor_left, cursor_right,
    output busy, done, full_iter_start, iter_en,
    output wr_en, wr_addr, wr_data, cursor_col, truncated
  );

  modport slave (
    output refresh, iter_out, iter_out_valid, cursor_left, cursor_right,
    input  busy, done, full_iter_start, iter_en,
    input  wr_en, wr_addr, wr_data, cursor_col, truncated
  );

endinterface

// File: rtl/text_view_reader.sv
// Iterates the text buffer on refresh and writes one padded display row.
// Optional TEXT_VIEW_READER_CURSOR_MARK_EN: mark the cursor cell with the wr_data MSB.
module text_view_reader
  import text_pkg::*;
#(
  parameter int unsigned COLUMNS = 80
) (
  input logic               clk,
  input logic               rst_n,
  text_view_reader_if.master bus
);

  localparam int unsigned COL_WIDTH = $clog2(COLUMNS + 1);
  localparam logic [COL_WIDTH-1:0] MAX_COL  = COL_WIDTH'(COLUMNS);
  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(COLUMNS - 1);

  reader_state_e            r_state;
  logic [COL_WIDTH-1:0]     r_col;
  logic [COL_WIDTH-1:0]     r_sym_cnt;
  logic                     r_wr_en;
  logic [COL_WIDTH-1:0]     r_wr_addr;
  logic [WR_DATA_WIDTH-1:0] r_wr_data;
  logic [COL_WIDTH-1:0]     r_cursor_col;
  logic                     r_truncated;

  logic                     w_active;
  logic                     w_take;
  logic                     w_end;
  logic                     w_fits;
  logic                     w_fix_now;
  logic [WR_DATA_WIDTH-1:0] w_sym_data;
  logic [WR_DATA_WIDTH-1:0] w_pad_data;
  logic [WR_DATA_WIDTH-1:0] w_fix_data;

  assign w_active = (r_state == ST_REQ) || (r_state == ST_RUN);
  assign w_take   = w_active && bus.iter_out_valid;
  assign w_end    = w_take && (bus.iter_out == END_SYMBOL);
  assign w_fits   = (r_col < MAX_COL);

  // The end marker drops iter_en in its own cycle so the buffer sees no extra advance.
  assign bus.full_iter_start = (r_state == ST_REQ) && !bus.iter_out_valid;
  assign bus.iter_en         = w_active && !w_end;
  assign bus.busy            = (r_state != ST_IDLE);
  assign bus.done            = (r_state == ST_DONE);
  assign bus.wr_en           = r_wr_en;
  assign bus.wr_addr         = r_wr_addr;
  assign bus.wr_data         = r_wr_data;
  assign bus.cursor_col      = r_cursor_col;
  assign bus.truncated       = r_truncated;

`ifdef TEXT_VIEW_READER_CURSOR_MARK_EN
  logic    r_mark_pend;
  logic    r_mark_fix;
  symbol_t r_last_sym;

  // Cursor past the last cell forces a re-write of cell COLUMNS-1 with the mark set.
  assign w_fix_now  = r_mark_fix || (bus.cursor_left && !w_fits);
  assign w_sym_data = {bus.cursor_left, bus.iter_out};
  assign w_pad_data = {r_mark_pend, BLANK_CODE};
  assign w_fix_data = {1'b1, r_last_sym};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mark_pend <= 1'b0;
      r_mark_fix  <= 1'b0;
      r_last_sym  <= '0;
    end else if (r_state == ST_IDLE) begin
      r_mark_pend <= 1'b0;
      r_mark_fix  <= 1'b0;
    end else if (w_take) begin
      if (bus.cursor_left && w_end && w_fits) r_mark_pend <= 1'b1;
      if (bus.cursor_left && !w_fits)         r_mark_fix  <= 1'b1;
      if (!w_end && w_fits)                   r_last_sym  <= bus.iter_out;
    end else if (r_state == ST_PAD) begin
      r_mark_pend <= 1'b0;
    end
  end
`else
  assign w_fix_now  = 1'b0;
  assign w_sym_data = bus.iter_out;
  assign w_pad_data = BLANK_CODE;
  assign w_fix_data = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_sym_cnt    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cursor_col <= '0;
      r_truncated  <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_col     <= '0;
          r_sym_cnt <= '0;
          if (bus.refresh) begin
            r_truncated <= 1'b0;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ, ST_RUN: begin
          if (bus.iter_out_valid) begin
            if (bus.cursor_left)
              r_cursor_col <= (r_sym_cnt == MAX_COL) ? LAST_COL : r_sym_cnt;
            if (w_end) begin
              r_state <= (!w_fits && !w_fix_now) ? ST_DONE : ST_PAD;
            end else begin
              r_state <= ST_RUN;
              if (r_sym_cnt != MAX_COL) r_sym_cnt <= r_sym_cnt + COL_WIDTH'(1);
              if (w_fits) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_col;
                r_wr_data <= w_sym_data;
                r_col     <= r_col + COL_WIDTH'(1);
              end else begin
                r_truncated <= 1'b1;
              end
            end
          end
        end
        ST_PAD: begin
          r_wr_en <= 1'b1;
          if (w_fits) begin
            r_wr_addr <= r_col;
            r_wr_data <= w_pad_data;
            r_col     <= r_col + COL_WIDTH'(1);
            if (r_col == LAST_COL) r_state <= ST_DONE;
          end else begin
            r_wr_addr <= LAST_COL;
            r_wr_data <= w_fix_data;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  a_cursor_excl: assert property (@(posedge clk) disable iff (!rst_n)
    w_take |-> !(bus.cursor_left && bus.cursor_right));

endmodule

// File: tb/tb_text_view_reader.sv
// Randomized bench for text_view_reader against a row-level reference model.
module tb_text_view_reader;
  import text_pkg::*;

  localparam int unsigned COLS = 8;
  localparam int unsigned WD   = WR_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  text_view_reader_if #(.COLUMNS(COLS)) bus ();
  text_view_reader #(.COLUMNS(COLS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  symbol_t         q_syms[$];
  int              cur_k;
  int              exp_wq_addr[$];
  logic [WD-1:0]   exp_wq_data[$];
  logic [WD-1:0]   cells[COLS];
  bit              in_iter       = 1'b0;
  bit              first_pending = 1'b0;
  logic            exp_iter_en   = 1'b0;
  logic            exp_fis       = 1'b0;
  int              done_cnt      = 0;
  int              fis_cycles    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of handshake outputs and of every row-memory write.
  always begin
    int            a;
    logic [WD-1:0] d;
    @(negedge clk);
    #2;
    if (rst_n) begin
      check("iter_en", 32'(bus.iter_en), 32'(exp_iter_en));
      check("full_iter_start", 32'(bus.full_iter_start), 32'(exp_fis));
      if (bus.full_iter_start) fis_cycles++;
      if (bus.done) done_cnt++;
      if (bus.wr_en) begin
        check("write_expected", 32'(exp_wq_addr.size() != 0), 32'd1);
        if (exp_wq_addr.size() != 0) begin
          a = exp_wq_addr.pop_front();
          d = exp_wq_data.pop_front();
          check("wr_addr", 32'(bus.wr_addr), 32'(a));
          check("wr_data", 32'(bus.wr_data), 32'(d));
        end
        if (bus.wr_addr < COLS) cells[bus.wr_addr] = bus.wr_data;
      end
    end
  end

  task automatic drive(input bit rf, input bit v, input symbol_t s, input bit cl, input bit cr);
    @(negedge clk);
    bus.refresh        = rf | (in_iter && ($urandom_range(0, 3) == 0));
    bus.iter_out_valid = v;
    bus.iter_out       = v ? s : SYMBOL_WIDTH'($urandom);
    bus.cursor_left    = cl;
    bus.cursor_right   = cr;
    exp_iter_en        = in_iter && !(v && (s == END_SYMBOL));
    exp_fis            = in_iter && first_pending && !v;
    if (v && in_iter) begin
      first_pending = 1'b0;
      if (s == END_SYMBOL) in_iter = 1'b0;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    check({tag, "_iter_en"}, 32'(bus.iter_en), 32'd0);
    check({tag, "_fis"}, 32'(bus.full_iter_start), 32'd0);
    check({tag, "_truncated"}, 32'(bus.truncated), 32'd0);
    check({tag, "_cursor_col"}, 32'(bus.cursor_col), 32'd0);
  endtask

  task automatic set_text(input string s, input int k);
    q_syms.delete();
    for (int i = 0; i < s.len(); i++) q_syms.push_back(SYMBOL_WIDTH'(s[i]));
    cur_k = k;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n              = 1'b0;
    bus.refresh        = 1'b0;
    bus.iter_out_valid = 1'b0;
    bus.cursor_left    = 1'b0;
    bus.cursor_right   = 1'b0;
    in_iter            = 1'b0;
    first_pending      = 1'b0;
    exp_iter_en        = 1'b0;
    exp_fis            = 1'b0;
    #1;
    check_zero("mid_reset");
    exp_wq_addr.delete();
    exp_wq_data.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: cells 0..n-1 hold text, the rest blanks; cursor k maps to min(k, COLS-1).
  task automatic run_row(input int pre_delay, input int max_gap, input int abort_at);
    int n;
    int exp_cc;
    bit seen;
    n = q_syms.size();
    exp_wq_addr.delete();
    exp_wq_data.delete();
    for (int i = 0; i < int'(COLS); i++) begin
      logic [WD-1:0] d;
      d = (i < n) ? WD'(q_syms[i]) : WD'(BLANK_CODE);
`ifdef TEXT_VIEW_READER_CURSOR_MARK_EN
      if (i == cur_k) d[WD-1] = 1'b1;
`endif
      exp_wq_addr.push_back(i);
      exp_wq_data.push_back(d);
      cells[i] = '0;
    end
`ifdef TEXT_VIEW_READER_CURSOR_MARK_EN
    if (cur_k >= int'(COLS)) begin
      exp_wq_addr.push_back(COLS - 1);
      exp_wq_data.push_back({1'b1, q_syms[COLS-1]});
    end
`endif
    exp_cc     = (cur_k < int'(COLS)) ? cur_k : int'(COLS) - 1;
    done_cnt   = 0;
    fis_cycles = 0;

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    in_iter       = 1'b1;
    first_pending = 1'b1;
    repeat (pre_delay) idle();
    for (int i = 0; i <= n; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      repeat ($urandom_range(0, max_gap)) idle();
      drive(1'b0, 1'b1, (i < n) ? q_syms[i] : END_SYMBOL,
            i == cur_k, (cur_k > 0) && (i == cur_k - 1));
    end

    seen = 1'b0;
    for (int c = 0; c < int'(COLS) + 6 && !seen; c++) begin
      idle();
      #3;
      if (done_cnt > 0) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("busy_at_done", 32'(bus.busy), 32'd1);
      check("truncated", 32'(bus.truncated), 32'(n > int'(COLS)));
      check("cursor_col", 32'(bus.cursor_col), 32'(exp_cc));
    end
    idle();
    #3;
    check("busy_after", 32'(bus.busy), 32'd0);
    check("done_after", 32'(bus.done), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("writes_left", 32'(exp_wq_addr.size()), 32'd0);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.refresh        = 1'b0;
    bus.iter_out_valid = 1'b0;
    bus.iter_out       = '0;
    bus.cursor_left    = 1'b0;
    bus.cursor_right   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    set_text("x+1", 3);
    run_row(2, 1, -1);
    check("pin_xp1_cell0", 32'(cells[0][SYMBOL_WIDTH-1:0]), 32'h78);
    check("pin_xp1_cell2", 32'(cells[2][SYMBOL_WIDTH-1:0]), 32'h31);
    check("pin_xp1_cell7", 32'(cells[7][SYMBOL_WIDTH-1:0]), 32'h20);
    check("pin_xp1_cursor", 32'(bus.cursor_col), 32'd3);

    set_text("", 0);
    run_row(0, 0, -1);
    check("pin_empty_cell0", 32'(cells[0][SYMBOL_WIDTH-1:0]), 32'h20);
    check("pin_empty_cursor", 32'(bus.cursor_col), 32'd0);

    set_text("ab", 2);
    run_row(40, 0, -1);
    check("fis_held_40", 32'(fis_cycles >= 40), 32'd1);

    set_text("abcdefghij", 9);
    run_row(1, 1, -1);
    check("pin_trunc_flag", 32'(bus.truncated), 32'd1);
    check("pin_trunc_cursor", 32'(bus.cursor_col), 32'd7);
    check("pin_trunc_cell7", 32'(cells[7][SYMBOL_WIDTH-1:0]), 32'h68);

    set_text("abcdefghij", 4);
    run_row(0, 0, 5);
    set_text("x+1", 3);
    run_row(0, 0, -1);
    check("pin_after_reset_cell1", 32'(cells[1][SYMBOL_WIDTH-1:0]), 32'h2b);

    set_text("ab", 1);
    run_row(0, 1, -1);
`ifdef TEXT_VIEW_READER_CURSOR_MARK_EN
    check("pin_mark_cell1", 32'(cells[1][WD-1]), 32'd1);
    check("pin_mark_cell0", 32'(cells[0][WD-1]), 32'd0);
`endif

    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(0, 12);
      q_syms.delete();
      for (int i = 0; i < n; i++) q_syms.push_back(SYMBOL_WIDTH'($urandom_range(1, 127)));
      cur_k = $urandom_range(0, n);
      run_row($urandom_range(0, 5), 2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
